// File: rtl/featuremap_channel_packer_if.sv
// rtl/featuremap_channel_packer_if.sv - channel input stream and packed pixel output bundle
// master drives channel values and downstream ready; slave is the packer side.
interface featuremap_channel_packer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 16
);
  logic [DATA_WIDTH-1:0]        data_in;
  logic                         valid_in;
  logic                         ready_in;
  logic [NUM_CH*DATA_WIDTH-1:0] data_out;
  logic                         valid_out;
  logic                         ready_out;
  logic                         line_last;
  logic                         frame_last;

  modport master (
    output data_in, valid_in, ready_out,
    input  ready_in, data_out, valid_out, line_last, frame_last
  );

  modport slave (
    input  data_in, valid_in, ready_out,
    output ready_in, data_out, valid_out, line_last, frame_last
  );
endinterface

// File: rtl/featuremap_channel_packer.sv
// rtl/featuremap_channel_packer.sv - packs NUM_CH serial channel values into one pixel word
// Two-deep storage: assembly register plus output register, with raster line/frame markers.
module featuremap_channel_packer #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 16,
  parameter int IMG_SIZE   = 208
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  featuremap_channel_packer_if.slave bus
);
  localparam int LANE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int POS_W  = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int WORD_W = NUM_CH * DATA_WIDTH;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(NUM_CH - 1);
  localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(IMG_SIZE - 1);

  logic [LANE_W-1:0] lane_cnt_q, lane_cnt_d;
  logic              asm_full_q, asm_full_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0] data_out_q, data_out_d;
  logic              valid_out_q, valid_out_d;
  logic              line_last_q, line_last_d;
  logic              frame_last_q, frame_last_d;
  logic [POS_W-1:0]  col_q, col_d;
  logic [POS_W-1:0]  row_q, row_d;

  logic move, ready_in, acc_in, xfer_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_cnt_q   <= '0;
      asm_full_q   <= 1'b0;
      asm_q        <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      line_last_q  <= 1'b0;
      frame_last_q <= 1'b0;
      col_q        <= '0;
      row_q        <= '0;
    end else begin
      lane_cnt_q   <= lane_cnt_d;
      asm_full_q   <= asm_full_d;
      asm_q        <= asm_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      line_last_q  <= line_last_d;
      frame_last_q <= frame_last_d;
      col_q        <= col_d;
      row_q        <= row_d;
    end
  end

  always_comb begin
    // The output register frees up in the same cycle it is drained, so a full
    // assembly can move and lane 0 of the next bundle can land together.
    move     = asm_full_q & (~valid_out_q | bus.ready_out);
    ready_in = ~asm_full_q | move;
    acc_in   = bus.valid_in & ready_in;
    xfer_out = valid_out_q & bus.ready_out;

    lane_cnt_d   = lane_cnt_q;
    asm_full_d   = asm_full_q;
    asm_d        = asm_q;
    data_out_d   = data_out_q;
    valid_out_d  = valid_out_q;
    line_last_d  = line_last_q;
    frame_last_d = frame_last_q;
    col_d        = col_q;
    row_d        = row_q;

    if (clear) begin
      lane_cnt_d   = '0;
      asm_full_d   = 1'b0;
      valid_out_d  = 1'b0;
      line_last_d  = 1'b0;
      frame_last_d = 1'b0;
      col_d        = '0;
      row_d        = '0;
    end else begin
      if (move) begin
        data_out_d   = asm_q;
        valid_out_d  = 1'b1;
        asm_full_d   = 1'b0;
        line_last_d  = (col_q == POS_LAST);
        frame_last_d = (col_q == POS_LAST) && (row_q == POS_LAST);
        if (col_q == POS_LAST) begin
          col_d = '0;
          row_d = (row_q == POS_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end else if (xfer_out) begin
        valid_out_d = 1'b0;
      end

      if (acc_in) begin
        asm_d[int'(lane_cnt_q)*DATA_WIDTH +: DATA_WIDTH] = bus.data_in;
        if (lane_cnt_q == LANE_LAST) begin
          lane_cnt_d = '0;
          asm_full_d = 1'b1;
        end else begin
          lane_cnt_d = lane_cnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.ready_in   = ready_in;
    bus.data_out   = data_out_q;
    bus.valid_out  = valid_out_q;
    bus.line_last  = line_last_q;
    bus.frame_last = frame_last_q;
  end
endmodule

// File: tb/tb_featuremap_channel_packer.sv
// tb/tb_featuremap_channel_packer.sv - self-checking bench for featuremap_channel_packer
// Queue-based packing model plus directed scenarios with literal expectations.
module tb_featuremap_channel_packer;
  localparam int DW  = 32;
  localparam int NCH = 16;
  localparam int IMG = 4;
  localparam int WW  = DW * NCH;

  typedef struct {
    logic [WW-1:0] word;
    logic          ll;
    logic          fl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clear = 1'b0;

  featuremap_channel_packer_if #(.DATA_WIDTH(DW), .NUM_CH(NCH)) bus ();

  featuremap_channel_packer #(.DATA_WIDTH(DW), .NUM_CH(NCH), .IMG_SIZE(IMG)) dut (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] lanes[$];
  exp_t          expq[$];
  int            pix = 0;
  int            cyc = 0;
  int            out_cnt = 0;
  int            out_cyc[$];
  logic          ll_q[$];
  logic          fl_q[$];
  logic [WW-1:0] last_word = '0;
  logic          prev_hold = 1'b0;
  logic [WW-1:0] prev_data = '0;

  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  // Model: accepted values collect in order; every NUM_CH of them is one pixel
  // whose markers follow from its raster index.
  always @(negedge clk) begin
    exp_t e;
    #4;
    cyc++;
    if (rst) begin
      lanes.delete();
      expq.delete();
      pix = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", WW'(bus.valid_out), WW'(1));
        chk("hold_data", bus.data_out, prev_data);
      end
      if (bus.valid_out && bus.ready_out) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual %0h required none", bus.data_out);
        end else begin
          e = expq.pop_front();
          chk("word_data", bus.data_out, e.word);
          chk("line_last", WW'(bus.line_last), WW'(e.ll));
          chk("frame_last", WW'(bus.frame_last), WW'(e.fl));
        end
        out_cnt++;
        last_word = bus.data_out;
        out_cyc.push_back(cyc);
        ll_q.push_back(bus.line_last);
        fl_q.push_back(bus.frame_last);
      end
      prev_hold = bus.valid_out && !bus.ready_out && !clear;
      prev_data = bus.data_out;
      if (clear) begin
        lanes.delete();
        expq.delete();
        pix = 0;
      end else if (bus.valid_in && bus.ready_in) begin
        lanes.push_back(bus.data_in);
        if (lanes.size() == NCH) begin
          for (int k = 0; k < NCH; k++) e.word[k*DW +: DW] = lanes[k];
          e.ll = ((pix % IMG) == IMG - 1);
          e.fl = e.ll && (((pix / IMG) % IMG) == IMG - 1);
          expq.push_back(e);
          pix++;
          lanes.delete();
        end
      end
    end
  end

  task automatic send(input logic [DW-1:0] v, output int tries);
    logic acc;
    tries = 0;
    acc = 1'b0;
    bus.valid_in = 1'b1;
    bus.data_in = v;
    while (!acc && tries < 200) begin
      #4;
      acc = bus.ready_in;
      @(negedge clk);
      tries++;
    end
    bus.valid_in = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual not_accepted required accepted");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid_out"}, WW'(bus.valid_out), WW'(0));
    chk({tag, "_ready_in"}, WW'(bus.ready_in), WW'(1));
    chk({tag, "_data_out"}, bus.data_out, '0);
    chk({tag, "_markers"}, WW'({bus.line_last, bus.frame_last}), WW'(0));
  endtask

  int acc_cnt = 0;

  initial begin
    int t;
    int stalls;
    int base;
    logic [WW-1:0] lit;

    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus.ready_out = 1'b1;

    // Reset state
    #2;
    check_reset_outputs("rst_init");
    @(negedge clk);
    rst = 1'b0;

    // Basic pack: lane 0 lands in the low bits, valid_out two cycles after last accept
    for (int i = 1; i <= 16; i++) send(DW'(i), t);
    #4;
    chk("pack_latency_n1", WW'(bus.valid_out), WW'(0));
    @(negedge clk);
    #4;
    chk("pack_latency_n2", WW'(bus.valid_out), WW'(1));
    lit = 512'h00000010_0000000f_0000000e_0000000d_0000000c_0000000b_0000000a_00000009_00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001;
    chk("pack_literal", bus.data_out, lit);
    @(negedge clk);

    // Asynchronous reset between clock edges while a word is held
    bus.ready_out = 1'b0;
    for (int i = 0; i < 16; i++) send(DW'(32'ha0 + i), t);
    repeat (3) @(negedge clk);
    chk("pre_rst_valid", WW'(bus.valid_out), WW'(1));
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;

    // Backpressure: two words buffered, then drained in order with the third
    base = out_cnt;
    fork
      begin
        int tt;
        for (int i = 0; i < 48; i++) begin
          send(DW'(32'h300 + i), tt);
          acc_cnt++;
        end
      end
    join_none
    repeat (40) @(negedge clk);
    #1;
    chk("bp_accepts", WW'(acc_cnt), WW'(32));
    chk("bp_ready_low", WW'(bus.ready_in), WW'(0));
    chk("bp_lane0", WW'(bus.data_out[31:0]), WW'(32'h300));
    chk("bp_lane15", WW'(bus.data_out[511:480]), WW'(32'h30f));
    @(negedge clk);
    bus.ready_out = 1'b1;
    t = 0;
    while (acc_cnt < 48 && t < 300) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
    chk("bp_words_out", WW'(out_cnt - base), WW'(3));

    // Streaming: 160 back-to-back values, no stalls, outputs every 16 cycles
    base = out_cnt;
    out_cyc.delete();
    stalls = 0;
    for (int i = 0; i < 160; i++) begin
      send(DW'(32'h400 + i), t);
      if (t != 1) stalls++;
    end
    repeat (4) @(negedge clk);
    chk("stream_stalls", WW'(stalls), WW'(0));
    chk("stream_words", WW'(out_cnt - base), WW'(10));
    for (int i = 1; i < out_cyc.size(); i++)
      chk("stream_spacing", WW'(out_cyc[i] - out_cyc[i-1]), WW'(16));

    // Markers on a 4x4 map, starting from a cleared position
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    ll_q.delete();
    fl_q.delete();
    for (int b = 0; b < 17; b++)
      for (int k = 0; k < 16; k++) send(DW'(32'h7000 + b*16 + k), t);
    repeat (4) @(negedge clk);
    chk("marker_words", WW'(ll_q.size()), WW'(17));
    if (ll_q.size() == 17) begin
      for (int w = 1; w <= 17; w++) begin
        chk("marker_ll", WW'(ll_q[w-1]), WW'((w % 4) == 0));
        chk("marker_fl", WW'(fl_q[w-1]), WW'(w == 16));
      end
    end

    // Flush with clear: the lane offered in the clear cycle is dropped
    for (int i = 0; i < 7; i++) send(DW'(32'h500 + i), t);
    clear = 1'b1;
    bus.valid_in = 1'b1;
    bus.data_in = 32'hdead;
    @(negedge clk);
    clear = 1'b0;
    bus.valid_in = 1'b0;
    base = out_cnt;
    for (int i = 0; i < 16; i++) send(DW'(32'h600 + i), t);
    t = 0;
    while (out_cnt == base && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("clear_word_seen", WW'(out_cnt - base), WW'(1));
    chk("clear_lane0", WW'(last_word[31:0]), WW'(32'h600));
    chk("clear_lane7", WW'(last_word[255:224]), WW'(32'h607));
    chk("clear_lane15", WW'(last_word[511:480]), WW'(32'h60f));

    // Flush with asynchronous reset mid-bundle
    for (int i = 0; i < 7; i++) send(DW'(32'h800 + i), t);
    #2;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    base = out_cnt;
    for (int i = 0; i < 16; i++) send(DW'(32'h900 + i), t);
    t = 0;
    while (out_cnt == base && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("rstflush_word_seen", WW'(out_cnt - base), WW'(1));
    chk("rstflush_lane0", WW'(last_word[31:0]), WW'(32'h900));
    chk("rstflush_lane15", WW'(last_word[511:480]), WW'(32'h90f));

    repeat (3) @(negedge clk);
    chk("model_drained", WW'(expq.size()), WW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
